// File: rtl/conv_pkg.sv
// Shared types and widths for the convolution output path.
package conv_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } wr_state_t;

   localparam int CONV_DATA_W = 64;
   localparam int CONV_CNT_W  = 20;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered first-word-fall-through head.
// A write into an empty FIFO appears on rd_data the cycle after the write edge.
module sync_fifo #(
   parameter int DEPTH = 512,
   parameter int WIDTH = 64,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      level
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_next;
   logic             wr_ok;
   logic             rd_ok;

   assign full        = (level == (AW+1)'(DEPTH));
   assign empty       = (level == '0);
   assign rd_ok       = rd_en && !empty;
   assign wr_ok       = wr_en && (!full || rd_ok);
   assign rd_ptr_next = rd_ok ? rd_ptr + AW'(1) : rd_ptr;

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   // The head register forwards the incoming word when it becomes the new head,
   // since the array read returns the old contents of that slot.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level   <= '0;
         rd_data <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         rd_ptr <= rd_ptr_next;
         if (wr_ok && !rd_ok) begin
            level <= level + (AW+1)'(1);
         end else if (!wr_ok && rd_ok) begin
            level <= level - (AW+1)'(1);
         end
         if (wr_ok && (wr_ptr == rd_ptr_next)) begin
            rd_data <= wr_data;
         end else if (rd_ok) begin
            rd_data <= mem[rd_ptr_next];
         end
      end
   end

endmodule

// File: rtl/conv_out_writer.sv
// Buffers one output group from conv_top and replays it as an AXI4-Stream master,
// flagging dropped beats (overflow) and unexpected beats (stray).
module conv_out_writer
   import conv_pkg::*;
#(
   parameter int FIFO_DEPTH = 512,
   parameter int DATA_W     = CONV_DATA_W,
   parameter int CNT_W      = CONV_CNT_W,
   localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CNT_W-1:0]  cfg_out_beats,
   input  logic              start,
   input  logic [DATA_W-1:0] data_in,
   input  logic              data_in_valid,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic              busy,
   output logic              done,
   output logic              overflow,
   output logic              stray,
   output logic [LW-1:0]     fifo_level
);

   wr_state_t        state;
   wr_state_t        state_next;
   logic [CNT_W-1:0] cfg_beats;
   logic [CNT_W-1:0] last_idx;
   logic [CNT_W-1:0] in_cnt;
   logic [CNT_W-1:0] out_cnt;
   logic             fifo_full;
   logic             fifo_empty;
   logic             wr_en;
   logic             fire;
   logic             start_go;
   logic             beat_accept;
   logic             in_last;
   logic             out_last;

   assign last_idx    = cfg_beats - CNT_W'(1);
   assign start_go    = (state == IDLE) && start;
   assign beat_accept = (state == RUN) && data_in_valid;
   assign in_last     = beat_accept && (in_cnt == last_idx);
   assign fire        = !fifo_empty && m_axis_tready;
   assign out_last    = fire && (out_cnt == last_idx);
   assign wr_en       = beat_accept && (!fifo_full || fire);

   assign m_axis_tvalid = !fifo_empty;
   assign m_axis_tlast  = !fifo_empty && (out_cnt == last_idx);

   sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (DATA_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (wr_en),
      .wr_data (data_in),
      .rd_en   (fire),
      .rd_data (m_axis_tdata),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // An overflow leaves the emitted count short, so DRAIN can wait forever; that is
   // intentional and firmware recovers with rst.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_next = (cfg_out_beats == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (in_last) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (out_last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state)
         RUN, DRAIN: busy = 1'b1;
         DONE:       done = 1'b1;
         default:    ;
      endcase
   end

   // A stray beat arriving in the same cycle as start still marks the new group.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cfg_beats <= '0;
         in_cnt    <= '0;
         out_cnt   <= '0;
         overflow  <= 1'b0;
         stray     <= 1'b0;
      end else begin
         if (start_go) begin
            cfg_beats <= cfg_out_beats;
            in_cnt    <= '0;
            out_cnt   <= '0;
            overflow  <= 1'b0;
         end else begin
            if (beat_accept) begin
               in_cnt <= in_cnt + CNT_W'(1);
            end
            if (fire) begin
               out_cnt <= out_cnt + CNT_W'(1);
            end
            if (beat_accept && fifo_full && !fire) begin
               overflow <= 1'b1;
            end
         end
         stray <= (start_go ? 1'b0 : stray) | (data_in_valid && (state != RUN));
      end
   end

endmodule
